// File: rtl/intc_isr_dispatch_pkg.sv
// Shared definitions for the interrupt controller ISR dispatch path:
// line count, vector width, dispatch FSM encoding and the ISR slot base
// addresses that the upstream config decoder maps onto slot indices.
package intc_isr_dispatch_pkg;

  localparam int INTC_NUM_IRQ = 4;
  localparam int INTC_ADDR_W  = 32;
  localparam int INTC_ID_W    = 2;

  // Dispatch handshake states: nothing offered, offer waiting for ack,
  // ISR running until end-of-interrupt.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } dispatch_state_t;

  // Config-space base address of each ISR vector slot; the decoder turns a
  // match on one of these into vec_wr_sel.
  localparam logic [31:0] ISR_SLOT_BASE_0 = 32'h0002_0000;
  localparam logic [31:0] ISR_SLOT_BASE_1 = 32'h0002_0020;
  localparam logic [31:0] ISR_SLOT_BASE_2 = 32'h0002_0040;
  localparam logic [31:0] ISR_SLOT_BASE_3 = 32'h0002_0060;

  // Base address of a given slot, for code that needs the reverse mapping.
  function automatic logic [31:0] isr_slot_base(input logic [INTC_ID_W-1:0] sel);
    logic [31:0] base;
    case (sel)
      2'd0:    base = ISR_SLOT_BASE_0;
      2'd1:    base = ISR_SLOT_BASE_1;
      2'd2:    base = ISR_SLOT_BASE_2;
      default: base = ISR_SLOT_BASE_3;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of the mask (line 0 is
// the most urgent) plus a flag saying whether any bit was set at all.
module intc_priority_encoder
  import intc_isr_dispatch_pkg::*;
#(
  parameter int N = INTC_NUM_IRQ,
  parameter int W = INTC_ID_W
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] id,
  output logic         any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        id  = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intc_isr_dispatch.sv
// ISR dispatcher: stores four ISR vectors written through the config
// decoder, latches rising IRQ edges as pending, and offers the most urgent
// pending line that has a valid vector to the CPU with an irq/ack/eoi
// handshake. One interrupt at a time; no nesting and no preemption of an
// outstanding offer.
module intc_isr_dispatch
  import intc_isr_dispatch_pkg::*;
#(
  parameter int NUM_IRQ = INTC_NUM_IRQ,
  parameter int ADDR_W  = INTC_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vec_wr_en,
  input  logic [1:0]         vec_wr_sel,
  input  logic               vec_wr_error,
  input  logic [ADDR_W-1:0]  vec_wr_data,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               cpu_irq,
  output logic [ADDR_W-1:0]  cpu_isr_addr,
  output logic [1:0]         active_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overrun
);

  // Per-line state
  logic [NUM_IRQ-1:0] irq_prev_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] overrun_reg;
  logic [NUM_IRQ-1:0] overrun_next;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] vec_valid;
  logic [NUM_IRQ-1:0] eligible;
  logic [ADDR_W-1:0]  vec_word [NUM_IRQ];

  // Dispatch FSM and its registered outputs
  dispatch_state_t    state_reg;
  dispatch_state_t    state_next;
  logic               cpu_irq_reg;
  logic               cpu_irq_next;
  logic [ADDR_W-1:0]  isr_addr_reg;
  logic [ADDR_W-1:0]  isr_addr_next;
  logic [1:0]         active_id_reg;
  logic [1:0]         active_id_next;

  logic [1:0]         win_id;
  logic               win_any;

  logic               slot_wr;

  // A write is only meaningful when the decoder resolved a real slot.
  assign slot_wr = vec_wr_en & ~vec_wr_error;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_slot
      logic [ADDR_W-1:0] vector_reg;
      logic              valid_reg;

      // Vector slot storage; valid flags that software has programmed it.
      always_ff @(posedge clk) begin
        if (rst) begin
          vector_reg <= '0;
          valid_reg  <= 1'b0;
        end else if (slot_wr && (vec_wr_sel == 2'(gi))) begin
          vector_reg <= vec_wr_data;
          valid_reg  <= 1'b1;
        end
      end

      assign vec_word[gi]  = vector_reg;
      assign vec_valid[gi] = valid_reg;

      // Edge detect, plus the clear that an accepted offer applies to its own line.
      assign rise[gi]    = irq_in[gi] & ~irq_prev_reg[gi];
      assign ack_clr[gi] = (state_reg == ST_OFFER) && cpu_ack && (active_id_reg == 2'(gi));

      // A fresh edge beats a simultaneous clear so no interrupt is lost.
      assign pending_next[gi] = (pending_reg[gi] & ~ack_clr[gi]) | rise[gi];
      // Sticky: an edge landed on a line that was still waiting.
      assign overrun_next[gi] = overrun_reg[gi] | (rise[gi] & pending_reg[gi]);
    end
  endgenerate

  // Lines without a programmed vector stay pending but are never offered.
  assign eligible = pending_reg & vec_valid;

  intc_priority_encoder #(
    .N (NUM_IRQ),
    .W (2)
  ) u_prio (
    .mask (eligible),
    .id   (win_id),
    .any  (win_any)
  );

  // Edge history, pending and overrun bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_reg <= '0;
      pending_reg  <= '0;
      overrun_reg  <= '0;
    end else begin
      irq_prev_reg <= irq_in;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
    end
  end

  // FSM state and registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cpu_irq_reg   <= 1'b0;
      isr_addr_reg  <= '0;
      active_id_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      cpu_irq_reg   <= cpu_irq_next;
      isr_addr_reg  <= isr_addr_next;
      active_id_reg <= active_id_next;
    end
  end

  // Next-state and output decisions for the irq/ack/eoi handshake.
  always_comb begin
    state_next     = state_reg;
    cpu_irq_next   = cpu_irq_reg;
    isr_addr_next  = isr_addr_reg;
    active_id_next = active_id_reg;
    case (state_reg)
      ST_IDLE: begin
        // Address is captured here, so later vector writes cannot disturb it.
        if (win_any) begin
          active_id_next = win_id;
          isr_addr_next  = vec_word[win_id];
          cpu_irq_next   = 1'b1;
          state_next     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // Hold the offer, even if a more urgent line arrives meanwhile.
        if (cpu_ack) begin
          cpu_irq_next = 1'b0;
          state_next   = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (cpu_eoi) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        cpu_irq_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  assign cpu_irq      = cpu_irq_reg;
  assign cpu_isr_addr = isr_addr_reg;
  assign active_id    = active_id_reg;
  assign pending      = pending_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_intc_isr_dispatch.sv
// Bench for intc_isr_dispatch: table-driven single-line dispatch cases,
// hand-written handshake/priority/overrun/reset sequences, and a random
// run compared against a rule-level reference model.
module tb_intc_isr_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        vec_wr_en;
  logic [1:0]  vec_wr_sel;
  logic        vec_wr_error;
  logic [31:0] vec_wr_data;
  logic [3:0]  irq_in;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        cpu_irq;
  logic [31:0] cpu_isr_addr;
  logic [1:0]  active_id;
  logic [3:0]  pending;
  logic [3:0]  overrun;

  int checks = 0;
  int errors = 0;

  intc_isr_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .vec_wr_en    (vec_wr_en),
    .vec_wr_sel   (vec_wr_sel),
    .vec_wr_error (vec_wr_error),
    .vec_wr_data  (vec_wr_data),
    .irq_in       (irq_in),
    .cpu_ack      (cpu_ack),
    .cpu_eoi      (cpu_eoi),
    .cpu_irq      (cpu_irq),
    .cpu_isr_addr (cpu_isr_addr),
    .active_id    (active_id),
    .pending      (pending),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [1:0]  line;
    logic        exp_irq;
    logic [31:0] exp_addr;
  } vec_case_t;

  vec_case_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    vec_wr_en    = 1'b0;
    vec_wr_sel   = 2'd0;
    vec_wr_error = 1'b0;
    vec_wr_data  = 32'd0;
    irq_in       = 4'd0;
    cpu_ack      = 1'b0;
    cpu_eoi      = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic write_vec(input logic [1:0] sel, input logic err, input logic [31:0] data);
    vec_wr_en    = 1'b1;
    vec_wr_sel   = sel;
    vec_wr_error = err;
    vec_wr_data  = data;
    step();
    vec_wr_en    = 1'b0;
    vec_wr_error = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irq"},     32'(cpu_irq),      32'd0);
    chk({tag, "_addr"},    cpu_isr_addr,      32'd0);
    chk({tag, "_id"},      32'(active_id),    32'd0);
    chk({tag, "_pending"}, 32'(pending),      32'd0);
    chk({tag, "_overrun"}, 32'(overrun),      32'd0);
  endtask

  // Reference model state
  bit [31:0] m_vec [4];
  bit [3:0]  m_valid, m_pend, m_ovr, m_prev;
  bit        m_offer, m_serv;
  bit [1:0]  m_id;
  bit [31:0] m_addr;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_vec[i] = 32'd0;
    m_valid = 4'd0; m_pend = 4'd0; m_ovr = 4'd0; m_prev = 4'd0;
    m_offer = 1'b0; m_serv = 1'b0; m_id = 2'd0; m_addr = 32'd0;
  endtask

  // One clock edge worth of behaviour, applied to the inputs seen at that edge.
  task automatic model_edge();
    bit [3:0] rise_m, clr_m, new_pend, new_ovr;
    bit       found;
    if (rst) begin
      model_clear();
    end else begin
      rise_m = irq_in & ~m_prev;
      clr_m  = 4'd0;
      if (m_offer && cpu_ack) clr_m[m_id] = 1'b1;
      new_ovr  = m_ovr | (rise_m & m_pend);
      new_pend = (m_pend & ~clr_m) | rise_m;
      if (!m_offer && !m_serv) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!found && m_pend[i] && m_valid[i]) begin
            found   = 1'b1;
            m_offer = 1'b1;
            m_id    = 2'(i);
            m_addr  = m_vec[i];
          end
        end
      end else if (m_offer) begin
        if (cpu_ack) begin
          m_offer = 1'b0;
          m_serv  = 1'b1;
        end
      end else if (cpu_eoi) begin
        m_serv = 1'b0;
      end
      if (vec_wr_en && !vec_wr_error) begin
        m_vec[vec_wr_sel]   = vec_wr_data;
        m_valid[vec_wr_sel] = 1'b1;
      end
      m_pend = new_pend;
      m_ovr  = new_ovr;
      m_prev = irq_in;
    end
  endtask

  initial begin
    bit       seen;
    logic [3:0] line_mask;

    tbl[0] = '{err: 1'b0, sel: 2'd2, data: 32'h0000_1200, line: 2'd2, exp_irq: 1'b1, exp_addr: 32'h0000_1200};
    tbl[1] = '{err: 1'b1, sel: 2'd0, data: 32'h0000_DEAD, line: 2'd0, exp_irq: 1'b0, exp_addr: 32'h0000_0000};
    tbl[2] = '{err: 1'b0, sel: 2'd3, data: 32'h0002_0060, line: 2'd3, exp_irq: 1'b1, exp_addr: 32'h0002_0060};
    tbl[3] = '{err: 1'b0, sel: 2'd1, data: 32'hFFFF_FFFC, line: 2'd1, exp_irq: 1'b1, exp_addr: 32'hFFFF_FFFC};
    tbl[4] = '{err: 1'b0, sel: 2'd0, data: 32'h0000_0100, line: 2'd1, exp_irq: 1'b0, exp_addr: 32'h0000_0000};
    tbl[5] = '{err: 1'b0, sel: 2'd0, data: 32'h0002_0000, line: 2'd0, exp_irq: 1'b1, exp_addr: 32'h0002_0000};

    // Reset state
    do_reset();
    chk_all_zero("reset");
    $display("seq reset: outputs checked");

    // Table: one vector write, one line rises, look at the dispatch decision
    for (int i = 0; i < 6; i++) begin
      do_reset();
      write_vec(tbl[i].sel, tbl[i].err, tbl[i].data);
      line_mask = 4'(1) << tbl[i].line;
      irq_in = line_mask;
      step();
      step();
      chk($sformatf("tbl%0d_irq", i),  32'(cpu_irq),   32'(tbl[i].exp_irq));
      chk($sformatf("tbl%0d_addr", i), cpu_isr_addr,   tbl[i].exp_addr);
      chk($sformatf("tbl%0d_id", i),   32'(active_id), tbl[i].exp_irq ? 32'(tbl[i].line) : 32'd0);
      chk($sformatf("tbl%0d_pend", i), 32'(pending),   32'(line_mask));
      irq_in = 4'd0;
      $display("tbl case %0d: sel=%0d err=%0b line=%0d irq=%0b addr=0x%08h", i,
               tbl[i].sel, tbl[i].err, tbl[i].line, cpu_irq, cpu_isr_addr);
    end

    // 1: pending line without a vector is never offered
    do_reset();
    irq_in = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (cpu_irq) seen = 1'b1;
    end
    chk("novec_irq_seen", 32'(seen), 32'd0);
    chk("novec_pending", 32'(pending), 32'h4);
    $display("seq no-vector: pending=%b", pending);

    // 2: full handshake on line 2
    do_reset();
    write_vec(2'd2, 1'b0, 32'h0000_1200);
    irq_in = 4'b0100;
    step();
    chk("hs_irq_at_E", 32'(cpu_irq), 32'd0);
    chk("hs_pend_at_E", 32'(pending), 32'h4);
    step();
    chk("hs_irq_E1", 32'(cpu_irq), 32'd1);
    chk("hs_addr", cpu_isr_addr, 32'h0000_1200);
    chk("hs_id", 32'(active_id), 32'd2);
    write_vec(2'd2, 1'b0, 32'h0000_7777);
    cpu_eoi = 1'b1;
    step();
    cpu_eoi = 1'b0;
    chk("hs_eoi_ignored_offer", 32'(cpu_irq), 32'd1);
    chk("hs_addr_kept", cpu_isr_addr, 32'h0000_1200);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("hs_ack_irq", 32'(cpu_irq), 32'd0);
    chk("hs_ack_pend", 32'(pending), 32'd0);
    irq_in = 4'd0;
    step();
    irq_in = 4'b0100;
    step();
    step();
    chk("hs_no_dispatch_in_service", 32'(cpu_irq), 32'd0);
    cpu_eoi = 1'b1;
    step();
    cpu_eoi = 1'b0;
    step();
    chk("hs_redispatch_after_eoi", 32'(cpu_irq), 32'd1);
    chk("hs_new_addr", cpu_isr_addr, 32'h0000_7777);
    $display("seq handshake: id=%0d addr=0x%08h", active_id, cpu_isr_addr);

    // 3: lines 3 and 1 together -> 1 first, then 3
    do_reset();
    write_vec(2'd0, 1'b0, 32'h100);
    write_vec(2'd1, 1'b0, 32'h200);
    write_vec(2'd2, 1'b0, 32'h300);
    write_vec(2'd3, 1'b0, 32'h400);
    irq_in = 4'b1010;
    step();
    step();
    chk("prio_first_id", 32'(active_id), 32'd1);
    chk("prio_first_addr", cpu_isr_addr, 32'h200);
    irq_in = 4'b1011;
    step();
    chk("prio_no_preempt", 32'(active_id), 32'd1);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    step();
    cpu_eoi = 1'b0;
    step();
    chk("prio_second_id", 32'(active_id), 32'd0);
    chk("prio_second_addr", cpu_isr_addr, 32'h100);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    step();
    cpu_eoi = 1'b0;
    step();
    chk("prio_third_id", 32'(active_id), 32'd3);
    chk("prio_third_addr", cpu_isr_addr, 32'h400);
    irq_in = 4'd0;
    $display("seq priority: order 1,0,3 observed up to id=%0d", active_id);

    // 5: overrun and rise coincident with ack
    do_reset();
    write_vec(2'd0, 1'b0, 32'h100);
    irq_in = 4'b0001;
    step();
    irq_in = 4'b0000;
    step();
    chk("ovr_offer", 32'(cpu_irq), 32'd1);
    chk("ovr_none_yet", 32'(overrun), 32'd0);
    irq_in = 4'b0001;
    step();
    chk("ovr_set", 32'(overrun), 32'h1);
    irq_in = 4'b0000;
    step();
    irq_in  = 4'b0001;
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("ovr_ack_irq", 32'(cpu_irq), 32'd0);
    chk("ovr_set_wins", 32'(pending), 32'h1);
    irq_in  = 4'b0000;
    cpu_eoi = 1'b1;
    step();
    cpu_eoi = 1'b0;
    step();
    chk("ovr_redispatch_irq", 32'(cpu_irq), 32'd1);
    chk("ovr_redispatch_id", 32'(active_id), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    $display("seq overrun: overrun=%b pending=%b", overrun, pending);

    // 6: reset in SERVICE, then in OFFER
    do_reset();
    write_vec(2'd1, 1'b0, 32'h200);
    irq_in = 4'b0010;
    step();
    step();
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst_service");
    step();
    step();
    step();
    chk("rst_vec_cleared_irq", 32'(cpu_irq), 32'd0);
    chk("rst_vec_cleared_pend", 32'(pending), 32'h2);
    write_vec(2'd1, 1'b0, 32'h200);
    step();
    step();
    chk("rst_offer_up", 32'(cpu_irq), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    irq_in = 4'd0;
    chk_all_zero("rst_offer");
    $display("seq reset-mid-handshake: irq=%0b", cpu_irq);

    // Random run against the reference model
    do_reset();
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) irq_in[b] = ~irq_in[b];
      cpu_ack      = ($urandom_range(0, 2) == 0);
      cpu_eoi      = ($urandom_range(0, 3) == 0);
      vec_wr_en    = ($urandom_range(0, 9) == 0);
      vec_wr_error = ($urandom_range(0, 3) == 0);
      vec_wr_sel   = 2'($urandom_range(0, 3));
      vec_wr_data  = $urandom;
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_irq",     32'(cpu_irq),   32'(m_offer));
      chk("rnd_addr",    cpu_isr_addr,   m_addr);
      chk("rnd_id",      32'(active_id), 32'(m_id));
      chk("rnd_pending", 32'(pending),   32'(m_pend));
      chk("rnd_overrun", 32'(overrun),   32'(m_ovr));
    end
    rst = 1'b0; vec_wr_en = 1'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0; irq_in = 4'd0;
    $display("seq random: 3000 cycles compared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
